// File: rtl/mat_loop_sequencer_pkg.sv
// Shared definitions for the matrix-multiply loop sequencer: state encoding
// and the default loop-bound width.
package mat_loop_sequencer_pkg;

    localparam int DEFAULT_DIM_WIDTH = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seqState_e;

endpackage

// File: rtl/mat_loop_sequencer_if.sv
// Command and beat handshake bundle between the RISC-V command port, the
// sequencer and the operand-fetch/MAC pipeline.
interface mat_loop_sequencer_if
    import mat_loop_sequencer_pkg::*;
#(
    parameter int DIM_WIDTH = DEFAULT_DIM_WIDTH
);
    logic                 startIn;
    logic                 abortIn;
    logic [DIM_WIDTH-1:0] rowsIn;
    logic [DIM_WIDTH-1:0] colsIn;
    logic [DIM_WIDTH-1:0] innerIn;
    logic                 readyIn;
    logic                 validOut;
    logic [DIM_WIDTH-1:0] iOut;
    logic [DIM_WIDTH-1:0] jOut;
    logic [DIM_WIDTH-1:0] kOut;
    logic                 firstOut;
    logic                 lastOut;
    logic                 busyOut;
    logic                 doneOut;

    modport slave (
        input  startIn, abortIn, rowsIn, colsIn, innerIn, readyIn,
        output validOut, iOut, jOut, kOut, firstOut, lastOut, busyOut, doneOut
    );

    modport master (
        output startIn, abortIn, rowsIn, colsIn, innerIn, readyIn,
        input  validOut, iOut, jOut, kOut, firstOut, lastOut, busyOut, doneOut
    );

endinterface

// File: rtl/mat_loop_sequencer_loop_index.sv
// One loop level: an index register that counts 0..lastVal and reports when
// it sits on its final value so the next outer level can advance.
module mat_loop_sequencer_loop_index
    import mat_loop_sequencer_pkg::*;
#(
    parameter int DIM_WIDTH = DEFAULT_DIM_WIDTH
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic                 clrIn,
    input  logic                 advIn,
    input  logic [DIM_WIDTH-1:0] lastValIn,
    output logic [DIM_WIDTH-1:0] idxOut,
    output logic                 wrapOut
);

    logic [DIM_WIDTH-1:0] idxR;

    assign wrapOut = (idxR == lastValIn);
    assign idxOut  = idxR;

    // Index register: clear on start, otherwise step or wrap on advance.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            idxR <= {DIM_WIDTH{1'b0}};
        end else if (clrIn) begin
            idxR <= {DIM_WIDTH{1'b0}};
        end else if (advIn) begin
            if (wrapOut) begin
                idxR <= {DIM_WIDTH{1'b0}};
            end else begin
                idxR <= idxR + {{(DIM_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            idxR <= idxR;
        end
    end

endmodule

// File: rtl/mat_loop_sequencer.sv
// Nested i/j/k loop sequencer: latches R, C, K on start and emits one index
// triple per accepted beat, flagging accumulator-clear and write-back beats.
module mat_loop_sequencer
    import mat_loop_sequencer_pkg::*;
#(
    parameter int DIM_WIDTH = DEFAULT_DIM_WIDTH
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    mat_loop_sequencer_if.slave  seqIf
);

    localparam logic [DIM_WIDTH-1:0] ZERO_IDX = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0] ONE_IDX  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    seqState_e            stateR;
    logic [DIM_WIDTH-1:0] rowsLastR;
    logic [DIM_WIDTH-1:0] colsLastR;
    logic [DIM_WIDTH-1:0] innerLastR;
    logic                 validR;
    logic                 firstR;
    logic                 lastR;
    logic                 busyR;
    logic                 doneR;

    logic [DIM_WIDTH-1:0] idxI;
    logic [DIM_WIDTH-1:0] idxJ;
    logic [DIM_WIDTH-1:0] idxK;
    logic                 wrapI;
    logic                 wrapJ;
    logic                 wrapK;

    logic                 startAccS;
    logic                 zeroBoundS;
    logic                 handshakeS;
    logic                 advKS;
    logic                 advJS;
    logic                 advIS;
    logic                 finalBeatS;
    logic                 lastNextS;

    // Handshake decode and the k -> j -> i carry chain.
    always_comb begin
        startAccS  = (stateR == SEQ_IDLE) && seqIf.startIn;
        zeroBoundS = (seqIf.rowsIn == ZERO_IDX) || (seqIf.colsIn == ZERO_IDX) ||
                     (seqIf.innerIn == ZERO_IDX);
        handshakeS = (stateR == SEQ_RUN) && validR && seqIf.readyIn;
        advKS      = handshakeS;
        advJS      = advKS && wrapK;
        advIS      = advJS && wrapJ;
        finalBeatS = advIS && wrapI;
        // After a k wrap the next beat has k=0, which is also last only when K=1.
        if (wrapK) begin
            lastNextS = (innerLastR == ZERO_IDX);
        end else begin
            lastNextS = ((idxK + ONE_IDX) == innerLastR);
        end
    end

    mat_loop_sequencer_loop_index #(.DIM_WIDTH(DIM_WIDTH)) uIdxK (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .clrIn     (startAccS),
        .advIn     (advKS),
        .lastValIn (innerLastR),
        .idxOut    (idxK),
        .wrapOut   (wrapK)
    );

    mat_loop_sequencer_loop_index #(.DIM_WIDTH(DIM_WIDTH)) uIdxJ (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .clrIn     (startAccS),
        .advIn     (advJS),
        .lastValIn (colsLastR),
        .idxOut    (idxJ),
        .wrapOut   (wrapJ)
    );

    mat_loop_sequencer_loop_index #(.DIM_WIDTH(DIM_WIDTH)) uIdxI (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .clrIn     (startAccS),
        .advIn     (advIS),
        .lastValIn (rowsLastR),
        .idxOut    (idxI),
        .wrapOut   (wrapI)
    );

    // Sequencer FSM with bound latches and registered status/beat flags.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            stateR     <= SEQ_IDLE;
            rowsLastR  <= ZERO_IDX;
            colsLastR  <= ZERO_IDX;
            innerLastR <= ZERO_IDX;
            validR     <= 1'b0;
            firstR     <= 1'b0;
            lastR      <= 1'b0;
            busyR      <= 1'b0;
            doneR      <= 1'b0;
        end else begin
            case (stateR)
                SEQ_IDLE: begin
                    if (startAccS) begin
                        rowsLastR  <= seqIf.rowsIn - ONE_IDX;
                        colsLastR  <= seqIf.colsIn - ONE_IDX;
                        innerLastR <= seqIf.innerIn - ONE_IDX;
                        busyR      <= 1'b1;
                        if (zeroBoundS) begin
                            stateR <= SEQ_DONE;
                            validR <= 1'b0;
                            firstR <= 1'b0;
                            lastR  <= 1'b0;
                            doneR  <= 1'b1;
                        end else begin
                            stateR <= SEQ_RUN;
                            validR <= 1'b1;
                            firstR <= 1'b1;
                            lastR  <= (seqIf.innerIn == ONE_IDX);
                            doneR  <= 1'b0;
                        end
                    end else begin
                        validR <= 1'b0;
                        firstR <= 1'b0;
                        lastR  <= 1'b0;
                        busyR  <= 1'b0;
                        doneR  <= 1'b0;
                    end
                end
                SEQ_RUN: begin
                    if (seqIf.abortIn) begin
                        stateR <= SEQ_IDLE;
                        validR <= 1'b0;
                        firstR <= 1'b0;
                        lastR  <= 1'b0;
                        busyR  <= 1'b0;
                        doneR  <= 1'b0;
                    end else if (finalBeatS) begin
                        stateR <= SEQ_DONE;
                        validR <= 1'b0;
                        firstR <= 1'b0;
                        lastR  <= 1'b0;
                        busyR  <= 1'b1;
                        doneR  <= 1'b1;
                    end else if (handshakeS) begin
                        firstR <= wrapK;
                        lastR  <= lastNextS;
                    end else begin
                        firstR <= firstR;
                        lastR  <= lastR;
                    end
                end
                SEQ_DONE: begin
                    stateR <= SEQ_IDLE;
                    validR <= 1'b0;
                    firstR <= 1'b0;
                    lastR  <= 1'b0;
                    busyR  <= 1'b0;
                    doneR  <= 1'b0;
                end
                default: begin
                    stateR <= SEQ_IDLE;
                    validR <= 1'b0;
                    firstR <= 1'b0;
                    lastR  <= 1'b0;
                    busyR  <= 1'b0;
                    doneR  <= 1'b0;
                end
            endcase
        end
    end

    assign seqIf.validOut = validR;
    assign seqIf.iOut     = idxI;
    assign seqIf.jOut     = idxJ;
    assign seqIf.kOut     = idxK;
    assign seqIf.firstOut = firstR;
    assign seqIf.lastOut  = lastR;
    assign seqIf.busyOut  = busyR;
    assign seqIf.doneOut  = doneR;

endmodule

// File: tb/tb_mat_loop_sequencer.sv
// Self-checking bench for mat_loop_sequencer: table of runs plus random runs
// checked against a nested-loop beat model, and reset/abort corner sequences.
module tb_mat_loop_sequencer;

    localparam int W = 8;

    typedef struct {
        int    r;
        int    c;
        int    k;
        bit    rndReady;
        bit    noise;
        int    abortAt;
        string name;
    } vec_t;

    typedef struct {
        int i;
        int j;
        int k;
        bit f;
        bit l;
    } beat_t;

    logic clk;
    logic rstN;
    int   nChecks;
    int   nFail;

    mat_loop_sequencer_if #(.DIM_WIDTH(W)) seqIf ();

    mat_loop_sequencer #(.DIM_WIDTH(W)) dut (
        .clkIn (clk),
        .rstIn (rstN),
        .seqIf (seqIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkAllZero(input string nm);
        chk({nm, " valid"}, int'(seqIf.validOut), 0);
        chk({nm, " busy"},  int'(seqIf.busyOut),  0);
        chk({nm, " done"},  int'(seqIf.doneOut),  0);
        chk({nm, " first"}, int'(seqIf.firstOut), 0);
        chk({nm, " last"},  int'(seqIf.lastOut),  0);
        chk({nm, " ijk"},   int'(seqIf.iOut) + int'(seqIf.jOut) + int'(seqIf.kOut), 0);
    endtask

    // Runs one sequence, comparing every beat with the lexicographic model.
    task automatic runSeq(input vec_t v);
        beat_t exp[$];
        beat_t b;
        int    got = 0;
        int    cyc = 0;
        bit    ended = 1'b0;
        bit    aborted = 1'b0;
        for (int i = 0; i < v.r; i++)
            for (int j = 0; j < v.c; j++)
                for (int k = 0; k < v.k; k++) begin
                    b.i = i; b.j = j; b.k = k; b.f = (k == 0); b.l = (k == v.k - 1);
                    exp.push_back(b);
                end
        @(negedge clk);
        seqIf.startIn = 1'b1;
        seqIf.rowsIn  = W'(v.r);
        seqIf.colsIn  = W'(v.c);
        seqIf.innerIn = W'(v.k);
        @(negedge clk);
        seqIf.startIn = 1'b0;
        seqIf.rowsIn  = W'($urandom);
        seqIf.colsIn  = W'($urandom);
        seqIf.innerIn = W'($urandom);
        chk({v.name, " busy_on_start"}, int'(seqIf.busyOut), 1);
        if (exp.size() == 0) begin
            chk({v.name, " zero_done"},  int'(seqIf.doneOut),  1);
            chk({v.name, " zero_valid"}, int'(seqIf.validOut), 0);
            @(negedge clk);
            chk({v.name, " zero_busy_end"}, int'(seqIf.busyOut), 0);
            chk({v.name, " zero_done_end"}, int'(seqIf.doneOut), 0);
            return;
        end
        while (!ended && cyc < 2000) begin
            chk({v.name, " valid"}, int'(seqIf.validOut), 1);
            chk({v.name, " done_early"}, int'(seqIf.doneOut), 0);
            chk({v.name, " i"}, int'(seqIf.iOut), exp[got].i);
            chk({v.name, " j"}, int'(seqIf.jOut), exp[got].j);
            chk({v.name, " k"}, int'(seqIf.kOut), exp[got].k);
            chk({v.name, " first"}, int'(seqIf.firstOut), int'(exp[got].f));
            chk({v.name, " last"},  int'(seqIf.lastOut),  int'(exp[got].l));
            seqIf.readyIn = v.rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.noise) begin
                seqIf.startIn = 1'($urandom_range(0, 1));
                seqIf.rowsIn  = W'($urandom);
                seqIf.colsIn  = W'($urandom);
                seqIf.innerIn = W'($urandom);
            end
            if (got == v.abortAt) begin
                seqIf.readyIn = 1'b1;
                seqIf.abortIn = 1'b1;
                aborted = 1'b1;
            end
            if (seqIf.readyIn) begin
                got++;
                if (got == exp.size() || aborted) ended = 1'b1;
            end
            @(negedge clk);
            cyc++;
            seqIf.abortIn = 1'b0;
            seqIf.startIn = 1'b0;
        end
        seqIf.readyIn = 1'b0;
        if (!ended) begin
            nChecks++;
            nFail++;
            $display("FAIL %s timeout: got %0d beats expected %0d", v.name, got, exp.size());
            return;
        end
        if (aborted) begin
            chk({v.name, " abort_valid"}, int'(seqIf.validOut), 0);
            chk({v.name, " abort_done"},  int'(seqIf.doneOut),  0);
            chk({v.name, " abort_busy"},  int'(seqIf.busyOut),  0);
            @(negedge clk);
            chk({v.name, " abort_done_later"}, int'(seqIf.doneOut), 0);
        end else begin
            chk({v.name, " end_valid"}, int'(seqIf.validOut), 0);
            chk({v.name, " end_done"},  int'(seqIf.doneOut),  1);
            chk({v.name, " end_busy"},  int'(seqIf.busyOut),  1);
            if (!v.rndReady) chk({v.name, " cycles"}, cyc, exp.size());
            @(negedge clk);
            chk({v.name, " idle_busy"}, int'(seqIf.busyOut), 0);
            chk({v.name, " idle_done"}, int'(seqIf.doneOut), 0);
        end
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        nChecks = 0;
        nFail   = 0;
        rstN    = 1'b0;
        seqIf.startIn = 1'b0;
        seqIf.abortIn = 1'b0;
        seqIf.readyIn = 1'b0;
        seqIf.rowsIn  = '0;
        seqIf.colsIn  = '0;
        seqIf.innerIn = '0;

        vecs.push_back('{2, 2, 3,   0, 0, -1, "r2c2k3"});
        vecs.push_back('{2, 2, 3,   1, 0, -1, "r2c2k3_rnd"});
        vecs.push_back('{3, 0, 5,   0, 0, -1, "c_zero"});
        vecs.push_back('{0, 4, 4,   0, 0, -1, "r_zero"});
        vecs.push_back('{1, 1, 1,   0, 0, -1, "r1c1k1"});
        vecs.push_back('{1, 1, 255, 0, 0, -1, "kmax"});
        vecs.push_back('{2, 2, 3,   0, 0,  5, "abort5"});
        vecs.push_back('{1, 1, 1,   0, 0, -1, "after_abort"});
        vecs.push_back('{3, 2, 1,   1, 1, -1, "k1_noise"});

        repeat (2) @(negedge clk);
        chkAllZero("reset");
        rstN = 1'b1;
        @(negedge clk);
        seqIf.abortIn = 1'b1;
        @(negedge clk);
        seqIf.abortIn = 1'b0;
        chkAllZero("abort_in_idle");

        for (int n = 0; n < vecs.size(); n++) runSeq(vecs[n]);

        for (int n = 0; n < 6; n++) begin
            rv.r        = $urandom_range(1, 3);
            rv.c        = $urandom_range(1, 3);
            rv.k        = $urandom_range(1, 4);
            rv.rndReady = 1'b1;
            rv.noise    = 1'b1;
            rv.abortAt  = (n % 2 == 1) ? $urandom_range(0, rv.r * rv.c * rv.k - 1) : -1;
            rv.name     = "rand";
            runSeq(rv);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        seqIf.startIn = 1'b1;
        seqIf.rowsIn  = W'(2);
        seqIf.colsIn  = W'(2);
        seqIf.innerIn = W'(3);
        @(negedge clk);
        seqIf.startIn = 1'b0;
        seqIf.readyIn = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_reset k", int'(seqIf.kOut), 1);
        #2;
        rstN = 1'b0;
        #1;
        chkAllZero("async_reset");
        seqIf.startIn = 1'b1;
        repeat (2) @(negedge clk);
        chkAllZero("start_in_reset");
        seqIf.startIn = 1'b0;
        seqIf.readyIn = 1'b0;
        #2;
        rstN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chkAllZero("post_reset_idle");
        rv = '{2, 1, 2, 1, 0, -1, "post_reset_run"};
        runSeq(rv);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
